boot_loader: RTL and testbench
==============================

# boot_loader

Byte-stream initiator for the 1024×16 boot RAM port: accepts framed commands on a byte input stream (e.g. from a UART receiver), writes payload bytes into the boot RAM with per-byte enables, reads RAM words back onto a byte output stream, and releases the CPU from reset on a Go command. It sits between the host serial link and the boot RAM's address/byteena/data/wren/q port. It drives that port as the sole master while the CPU is held in reset.

## Interface
Parameters:
- CMD_WRITE, 8'h57 ('W'), write-block command byte
- CMD_READ, 8'h52 ('R'), read-block command byte
- CMD_GO, 8'h47 ('G'), release-CPU command byte

Ports:
- clock  in  1  single clock, rising edge
- nreset  in  1  asynchronous, active-low reset
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts rx_data this cycle (transfer when rx_valid & rx_ready)
- tx_data  out  8  outgoing byte
- tx_valid  out  1  tx_data valid; held with tx_data stable until accepted
- tx_ready  in  1  sink accepts tx_data
- address  out  10  RAM word address
- byteena  out  2  RAM byte enables ([1] = bits 15:8)
- data  out  16  RAM write data
- wren  out  1  RAM write strobe, one-cycle pulse
- q  in  16  RAM read data, valid one clock after address is presented
- cpu_run  out  1  0 holds CPU in reset; set by Go, cleared only by nreset
- error  out  1  one-cycle pulse on unknown command byte

## Operation
- Frame: CMD, ADDR_HI (bits 1:0 = address[9:8], bits 7:2 ignored), ADDR_LO, COUNT (words; 0 means 256), then payload.
- States: IDLE, ADDR_HI, ADDR_LO, COUNT, WR_HI, WR_LO, WR_SUM, RD_FETCH, RD_HI, RD_LO, GO.
- IDLE: consume a byte. W or R goes to ADDR_HI. G goes to GO. Any other value pulses error and stays in IDLE.
- WRITE path, per word:
  - WR_HI: the accepted byte b produces one RAM write with byteena=2'b10, data={b,b}.
  - WR_LO: the accepted byte produces one RAM write with byteena=2'b01, data={b,b}; then address increments.
  - Running checksum = 8-bit sum (mod 256) of all payload bytes.
  - After the last word, WR_SUM sends the checksum byte on tx, then returns to IDLE.
- READ path, per word:
  - RD_FETCH holds the address for one cycle; q is captured on the following edge.
  - RD_HI sends q[15:8]; RD_LO sends q[7:0]; address then increments.
  - Repeat for COUNT words, then return to IDLE.
- GO: set cpu_run=1, then return to IDLE. Further commands are still serviced.
- Address increment wraps 1023 → 0. The word counter is 9 bits so that 256 is representable.
- While cpu_run=1, W and R commands are still honoured. Preventing port contention with the CPU is the system's responsibility.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, address=0, byteena=2'b00, data=0, wren=0, rx_ready=0 during reset, tx_valid=0, tx_data=0, cpu_run=0, error=0, checksum=0.
- rx_ready=1 only in IDLE, ADDR_HI, ADDR_LO, COUNT, WR_HI and WR_LO, and only when no write is pending.
- Write timing: a byte accepted on edge N gives wren=1 with address/byteena/data valid for exactly the cycle after edge N. rx_ready=0 during that write cycle, so at most one byte is accepted per 2 cycles.
- Read latency: address is stable at edge N; q is sampled at edge N+1; tx_valid rises in the cycle after edge N+1.
- tx handshake: tx_valid stays high and tx_data stays stable until the edge where tx_ready=1. tx_valid may already be high when tx_ready arrives. With tx_ready held at 1, a read word takes 3 cycles.
- wren is 0 in every state except the single write cycle. byteena is 2'b00 whenever wren=0.
- Reset mid-frame aborts the frame immediately, with no partial write beyond writes already strobed. After reset, the next byte is parsed as a command.
- error is asserted in the cycle after the bad byte is accepted.

## Test plan
- Reset: assert nreset=0 mid-WR_LO while wren=1 -> all outputs at reset values in the same cycle. Release, then send W,00,10,01,AB,CD -> RAM[0x010]=16'hABCD, tx emits 8'h78.
- Wrap and count=0: W,03,FF,02,11,22,33,44 -> RAM[0x3FF]=16'h1122, RAM[0x000]=16'h3344, tx 8'hAA. Then W,00,00,00 followed by 512 bytes -> 256 words written, checksum correct.
- Read with backpressure: preload RAM[0x005]=16'hBEEF, RAM[0x006]=16'h1234. Send R,00,05,02 with tx_ready toggling every cycle -> tx bytes EF? no: BE,EF,12,34 in that order, each byte held stable until accepted.
- Byte-enable integrity: RAM[0x020]=16'hFFFF, then W,00,20,01,5A,A5 -> exactly two wren pulses (byteena 10 then 01), final RAM[0x020]=16'h5AA5.
- Bad command: send 8'h00 -> one-cycle error pulse, no wren. A following G -> cpu_run=1 and stays 1 through a subsequent R command.
- rx_valid gaps: insert random idle cycles between payload bytes of a 4-word write -> contents and checksum unchanged.

Source files
------------

// File: rtl/boot_loader.sv
// boot_loader: byte-stream command parser that drives the 1024x16 boot RAM
// port (write with byte enables, read-back onto tx) and releases the CPU
// from reset on a Go command.
module boot_loader #(
  parameter logic [7:0] CMD_WRITE = 8'h57,
  parameter logic [7:0] CMD_READ  = 8'h52,
  parameter logic [7:0] CMD_GO    = 8'h47
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [9:0]  address,
  output logic [1:0]  byteena,
  output logic [15:0] data,
  output logic        wren,
  input  logic [15:0] q,
  output logic        cpu_run,
  output logic        error
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR_HI, S_ADDR_LO, S_COUNT, S_WR_HI, S_WR_LO,
    S_WR_SUM, S_RD_FETCH, S_RD_HI, S_RD_LO, S_GO
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        accept;
  logic        is_read;
  logic [8:0]  count;
  logic [7:0]  checksum;
  logic [7:0]  sum_next;
  logic [7:0]  rd_lo;

  assign accept   = rx_valid & rx_ready;
  assign sum_next = checksum + rx_data;

  // State register
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) state <= S_IDLE;
    else         state <= state_next;
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (rx_data == CMD_WRITE || rx_data == CMD_READ) state_next = S_ADDR_HI;
          else if (rx_data == CMD_GO)                      state_next = S_GO;
        end
      end
      S_ADDR_HI:  if (accept) state_next = S_ADDR_LO;
      S_ADDR_LO:  if (accept) state_next = S_COUNT;
      S_COUNT:    if (accept) state_next = is_read ? S_RD_FETCH : S_WR_HI;
      S_WR_HI:    if (accept) state_next = S_WR_LO;
      S_WR_LO:    if (accept) state_next = (count == 9'd1) ? S_WR_SUM : S_WR_HI;
      S_WR_SUM:   if (tx_ready) state_next = S_IDLE;
      S_RD_FETCH: state_next = S_RD_HI;
      S_RD_HI:    if (tx_ready) state_next = S_RD_LO;
      S_RD_LO:    if (tx_ready) state_next = (count == 9'd1) ? S_IDLE : S_RD_FETCH;
      S_GO:       state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // rx_ready: byte-accepting states only, never during a write strobe or reset
  always_comb begin
    rx_ready = 1'b0;
    case (state)
      S_IDLE, S_ADDR_HI, S_ADDR_LO, S_COUNT, S_WR_HI, S_WR_LO: rx_ready = nreset & ~wren;
      default: rx_ready = 1'b0;
    endcase
  end

  // Datapath: RAM port, tx stream, counters, checksum and CPU release
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      address  <= '0;
      byteena  <= 2'b00;
      data     <= '0;
      wren     <= 1'b0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      cpu_run  <= 1'b0;
      error    <= 1'b0;
      checksum <= '0;
      count    <= '0;
      is_read  <= 1'b0;
      rd_lo    <= '0;
    end else begin
      wren    <= 1'b0;
      byteena <= 2'b00;
      error   <= 1'b0;
      // The low-byte write closes a word; step to the next word after it.
      if (wren && byteena == 2'b01) address <= address + 10'd1;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (rx_data == CMD_WRITE) begin
              is_read  <= 1'b0;
              checksum <= '0;
            end else if (rx_data == CMD_READ) begin
              is_read <= 1'b1;
            end else if (rx_data != CMD_GO) begin
              error <= 1'b1;
            end
          end
        end
        S_ADDR_HI: if (accept) address[9:8] <= rx_data[1:0];
        S_ADDR_LO: if (accept) address[7:0] <= rx_data;
        // A count byte of zero encodes 256 words.
        S_COUNT:   if (accept) count <= {(rx_data == 8'd0), rx_data};
        S_WR_HI: begin
          if (accept) begin
            wren     <= 1'b1;
            byteena  <= 2'b10;
            data     <= {rx_data, rx_data};
            checksum <= sum_next;
          end
        end
        S_WR_LO: begin
          if (accept) begin
            wren     <= 1'b1;
            byteena  <= 2'b01;
            data     <= {rx_data, rx_data};
            checksum <= sum_next;
            count    <= count - 9'd1;
            // Last payload byte: queue the final checksum straight away.
            if (count == 9'd1) begin
              tx_data  <= sum_next;
              tx_valid <= 1'b1;
            end
          end
        end
        S_WR_SUM: if (tx_ready) tx_valid <= 1'b0;
        S_RD_FETCH: begin
          tx_data  <= q[15:8];
          rd_lo    <= q[7:0];
          tx_valid <= 1'b1;
        end
        S_RD_HI: begin
          // The word is already captured, so the address can advance now;
          // this lets the next fetch overlap the low-byte transfer.
          if (tx_ready) begin
            tx_data <= rd_lo;
            address <= address + 10'd1;
          end
        end
        S_RD_LO: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            count    <= count - 9'd1;
          end
        end
        S_GO:    cpu_run <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed bench for boot_loader with a behavioural boot RAM
// model and a tx sink that records bytes and handshake cycles.
module tb_boot_loader;

  logic        clock = 1'b0;
  logic        nreset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [9:0]  address;
  logic [1:0]  byteena;
  logic [15:0] data;
  logic        wren;
  logic [15:0] q = '0;
  logic        cpu_run;
  logic        error;

  int checks = 0;
  int errors = 0;

  boot_loader dut (
    .clock(clock), .nreset(nreset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .address(address), .byteena(byteena), .data(data), .wren(wren),
    .q(q), .cpu_run(cpu_run), .error(error)
  );

  always #5 clock = ~clock;

  // RAM model: synchronous read, byte-enabled write
  logic [15:0] ram [1024];
  always @(posedge clock) begin
    q <= ram[address];
    if (wren) begin
      if (byteena[1]) ram[address][15:8] = data[15:8];
      if (byteena[0]) ram[address][7:0]  = data[7:0];
    end
  end

  // Monitors: write strobes, tx sink, tx hold stability
  int          cyc = 0;
  int          wren_cnt = 0;
  int          be_err = 0;
  int          hold_err = 0;
  logic [3:0]  be_hist = '0;
  logic [7:0]  txq [$];
  int          txt [$];
  logic        prev_pend = 1'b0;
  logic [7:0]  prev_data = '0;
  bit          tog = 1'b0;

  always @(posedge clock) begin
    cyc++;
    if (wren) begin
      wren_cnt++;
      be_hist = {be_hist[1:0], byteena};
    end else if (byteena != 2'b00) be_err++;
    if (!nreset) prev_pend = 1'b0;
    else begin
      if (prev_pend && (!tx_valid || tx_data != prev_data)) hold_err++;
      if (tx_valid && tx_ready) begin
        txq.push_back(tx_data);
        txt.push_back(cyc);
      end
      prev_pend = tx_valid && !tx_ready;
      prev_data = tx_data;
    end
  end

  always @(negedge clock) tx_ready = tog ? ~tx_ready : 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!rx_ready) begin
      checks++;
      errors++;
      $display("FAIL rx_accept: rx_ready got 0, required 1 (byte %0h)", b);
    end else @(posedge clock);
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [9:0] a, input logic [7:0] cnt);
    send_byte(cmd);
    send_byte({6'b0, a[9:8]});
    send_byte(a[7:0]);
    send_byte(cnt);
  endtask

  task automatic wait_tx(input int n, input string name);
    int c = 0;
    while (txq.size() < n && c < 2000) begin
      @(negedge clock);
      c++;
    end
    if (txq.size() < n) begin
      checks++;
      errors++;
      $display("FAIL %s: tx bytes got %0d, required %0d", name, txq.size(), n);
    end
  endtask

  function automatic logic [7:0] pop_tx();
    if (txq.size() == 0) return 8'hxx;
    void'(txt.pop_front());
    return txq.pop_front();
  endfunction

  typedef struct {
    logic [9:0]  addr;
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [15:0] prior;
    logic [15:0] exp_word;
    logic [7:0]  exp_sum;
  } vec_t;

  vec_t        vecs [4];
  logic [7:0]  gap_b [8];
  logic [7:0]  b;
  logic [7:0]  sum;
  int          bad;
  int          t0;

  initial begin
    vecs[0] = '{10'h010, 8'hAB, 8'hCD, 16'h0000, 16'hABCD, 8'h78};
    vecs[1] = '{10'h020, 8'h5A, 8'hA5, 16'hFFFF, 16'h5AA5, 8'hFF};
    vecs[2] = '{10'h3FF, 8'h00, 8'h00, 16'h1234, 16'h0000, 8'h00};
    vecs[3] = '{10'h155, 8'hFF, 8'hFF, 16'h0000, 16'hFFFF, 8'hFE};
    gap_b = '{8'hC3, 8'h5A, 8'h00, 8'hFF, 8'h81, 8'h7E, 8'h12, 8'h34};
    for (int i = 0; i < 1024; i++) ram[i] = 16'h0000;

    nreset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    @(negedge clock); @(negedge clock);
    check("reset_outputs", {address, byteena, data, wren, rx_ready, tx_valid, tx_data, cpu_run, error}, '0);
    nreset = 1'b1;
    @(negedge clock);
    check("idle_rx_ready", rx_ready, 1'b1);

    // Reset while the high-byte write strobe is active
    send_hdr(8'h57, 10'h010, 8'h01);
    send_byte(8'hAB);
    check("wr_strobe_before_reset", {wren, byteena, data}, {1'b1, 2'b10, 16'hABAB});
    check("rx_ready_low_during_write", rx_ready, 1'b0);
    #2 nreset = 1'b0;
    #1 check("async_reset_outputs", {address, byteena, data, wren, rx_ready, tx_valid, tx_data, cpu_run, error}, '0);
    @(negedge clock);
    nreset = 1'b1;
    @(negedge clock);

    // Single-word write table
    for (int i = 0; i < 4; i++) begin
      ram[vecs[i].addr] = vecs[i].prior;
      wren_cnt = 0;
      be_hist  = '0;
      send_hdr(8'h57, vecs[i].addr, 8'h01);
      send_byte(vecs[i].hi);
      send_byte(vecs[i].lo);
      wait_tx(1, $sformatf("wr%0d_tx", i));
      check($sformatf("wr%0d_sum", i), pop_tx(), vecs[i].exp_sum);
      check($sformatf("wr%0d_ram", i), ram[vecs[i].addr], vecs[i].exp_word);
      check($sformatf("wr%0d_strobes", i), {wren_cnt[7:0], be_hist}, {8'd2, 4'b1001});
    end

    // Address wrap 0x3FF -> 0x000
    wren_cnt = 0;
    send_hdr(8'h57, 10'h3FF, 8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    wait_tx(1, "wrap_tx");
    check("wrap_sum", pop_tx(), 8'hAA);
    check("wrap_ram_3ff", ram[10'h3FF], 16'h1122);
    check("wrap_ram_000", ram[10'h000], 16'h3344);
    check("wrap_strobes", wren_cnt, 4);

    // Count byte 0 means 256 words
    ram[10'h100] = 16'h5555;
    wren_cnt = 0;
    sum = '0;
    send_hdr(8'h57, 10'h000, 8'h00);
    for (int i = 0; i < 512; i++) begin
      b = 8'((i * 37) + 11);
      sum += b;
      send_byte(b);
    end
    wait_tx(1, "c256_tx");
    check("c256_sum", pop_tx(), sum);
    bad = 0;
    for (int k = 0; k < 256; k++)
      if (ram[k] !== {8'((2 * k * 37) + 11), 8'(((2 * k + 1) * 37) + 11)}) bad++;
    check("c256_words_bad", bad, 0);
    check("c256_no_overrun", ram[10'h100], 16'h5555);
    check("c256_strobes", wren_cnt, 512);

    // Read with tx backpressure
    ram[10'h005] = 16'hBEEF;
    ram[10'h006] = 16'h1234;
    wren_cnt = 0;
    hold_err = 0;
    tog = 1'b1;
    send_hdr(8'h52, 10'h005, 8'h02);
    wait_tx(4, "rd_bp_tx");
    tog = 1'b0;
    check("rd_bp_b0", pop_tx(), 8'hBE);
    check("rd_bp_b1", pop_tx(), 8'hEF);
    check("rd_bp_b2", pop_tx(), 8'h12);
    check("rd_bp_b3", pop_tx(), 8'h34);
    check("rd_bp_hold", hold_err, 0);
    check("rd_no_wren", wren_cnt, 0);
    @(negedge clock); @(negedge clock);

    // Bad command, then Go
    wren_cnt = 0;
    send_byte(8'h00);
    check("bad_err_pulse", error, 1'b1);
    @(negedge clock);
    check("bad_err_clear", error, 1'b0);
    check("bad_no_wren", wren_cnt, 0);
    check("cpu_run_before_go", cpu_run, 1'b0);
    send_byte(8'h47);
    @(negedge clock);
    check("cpu_run_set", cpu_run, 1'b1);
    check("go_no_error", error, 1'b0);

    // Read after Go with tx_ready held high: 3 cycles per word
    send_hdr(8'h52, 10'h005, 8'h02);
    wait_tx(4, "rd_go_tx");
    if (txt.size() >= 3) begin
      t0 = txt[0];
      check("rd_word_period", txt[2] - t0, 3);
    end
    check("rd_go_b0", pop_tx(), 8'hBE);
    check("rd_go_b1", pop_tx(), 8'hEF);
    check("rd_go_b2", pop_tx(), 8'h12);
    check("rd_go_b3", pop_tx(), 8'h34);
    check("cpu_run_held", cpu_run, 1'b1);

    // Write with idle gaps between payload bytes
    send_hdr(8'h57, 10'h040, 8'h04);
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clock);
      send_byte(gap_b[i]);
    end
    wait_tx(1, "gap_tx");
    check("gap_sum", pop_tx(), 8'h61);
    check("gap_ram", {ram[10'h040], ram[10'h041], ram[10'h042], ram[10'h043]},
          64'hC35A_00FF_817E_1234);

    check("byteena_idle_zero", be_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
